voice_allocator: RTL and testbench
==================================

# voice_allocator

Polyphonic voice controller for the synthesizer's bank of square-wave oscillators. Accepts a stream of note-on/note-off events through a valid/ready handshake and assigns each note to one of `NUM_VOICES` oscillator slots. It drives each slot's 19-bit period word, and a period of 0 silences the slot. When every slot is busy, it retriggers, steals or drops according to fixed priority rules.

## Interface
- `NUM_VOICES`, 4, number of oscillator slots (2..16).
- `clk48m` input 1: system clock, 48 MHz.
- `rst` input 1: synchronous, active-high reset.
- `ev_valid` input 1: event present.
- `ev_ready` output 1: block can accept an event; high only in IDLE.
- `ev_on` input 1: 1 = note-on, 0 = note-off.
- `ev_note` input 7: MIDI note number.
- `ev_period` input 19: oscillator period for note-on; ignored for note-off.
- `all_off` input 1: panic; silences all slots.
- `voice_period` output 19*NUM_VOICES: slot v occupies bits [19v+18:19v].
- `voice_active` output NUM_VOICES: per-slot busy flag.
- `ev_dropped` output 1: one-cycle pulse when a note-on is discarded.
- `ev_stolen` output 1: one-cycle pulse when a busy slot is reassigned.

## Operation
- Per-slot state: `active`, `note[6:0]`, `period[18:0]`, and `stamp[7:0]`. A global 8-bit `seq` counter increments on every successful note-on and wraps modulo 256.
- FSM states:
  - IDLE: `ev_ready`=1. On `ev_valid & ev_ready`, latch on/note/period, set idx=0, go to SCAN.
  - SCAN: examine slot idx, one slot per cycle, and track:
    - first slot whose note matches and is active;
    - lowest-index inactive slot;
    - oldest active slot, with age = (seq - stamp) mod 256, ties resolved to the lowest index.
    - At idx = NUM_VOICES-1, go to APPLY.
  - APPLY: commit the decision, then go to IDLE.
- Note-on decision, in priority order:
  1. Matching active slot: retrigger it. Write the new period, stamp = seq, seq+1.
  2. Otherwise, the lowest free slot: set active=1, write note, period and stamp, seq+1.
  3. Otherwise, steal or drop (see Configuration).
- A note-on with `ev_period`=0 is handled exactly as a note-off for that note.
- Note-off: the matching active slot gets active=0 and period=0. With no match, nothing changes and nothing is pulsed.
- The retrigger rule guarantees at most one active slot per note.
- `all_off`:
  - In any state, it clears every slot (active=0, period=0) next cycle and forces the FSM to IDLE.
  - A latched in-flight event is discarded without pulses.
  - `seq` is unchanged.
- `voice_period[v]` = period of slot v when active, else 0. All outputs are registered.

## Timing
- Reset values: state IDLE, `ev_ready`=1, all `voice_period`=0, `voice_active`=0, pulses 0, `seq`=0, all stamps 0.
- The event is accepted at edge T. SCAN occupies T+1..T+NUM_VOICES. APPLY writes at edge T+NUM_VOICES+1, where the new `voice_*` values and pulses are visible.
- `ev_ready` returns high the same cycle the update is visible. Maximum throughput is one event per NUM_VOICES+2 cycles.
- `ev_ready` is low during SCAN/APPLY. `ev_valid` held there is not consumed, and the event fields must stay stable until accepted.
- `rst` overrides `all_off`, and `all_off` overrides APPLY in the same cycle.

## Configuration
- `VOICE_STEAL_EN` defined: when all slots are active, a note-on takes the oldest slot.
  - Write note, period and stamp to that slot, seq+1, and pulse `ev_stolen`.
  - `ev_dropped` never fires.
- `VOICE_STEAL_EN` undefined: when all slots are active, the note-on is discarded.
  - Slots and `seq` are unchanged, and `ev_dropped` pulses.
  - `ev_stolen` is tied 0.

## Test plan
- Reset, then on note 60 period 1000 → after 6 cycles (NUM_VOICES=4): slot0 active, `voice_period[18:0]`=1000, `ev_ready`=1.
- Notes 60, 62, 64, 65 on; then off 62 → slot1 period 0, active mask 4'b1101. A subsequent on 67 lands in slot1.
- On 60 period 1000, then on 60 period 500 → only slot0 used, with period 500. Mask stays 4'b0001.
- Four slots busy, then on 69:
  - with `VOICE_STEAL_EN`: slot0 (oldest) takes 69 and `ev_stolen` pulses once;
  - without it: `ev_dropped` pulses and slots are unchanged.
- Assert `all_off` during SCAN of an on event → next cycle all periods 0, mask 0, `ev_ready`=1, no pulses.
- 300 retriggers of slot0 while slot1 holds an older note, then fill and steal → slot1 is chosen despite the `seq` wrap.

Source files
------------

// File: rtl/voice_allocator.sv
// voice_allocator: assigns note events to NUM_VOICES oscillator slots; define VOICE_STEAL_EN to steal the oldest slot when all are busy
module voice_allocator #(
  parameter int NUM_VOICES = 4
) (
  input  logic                       clk48m,
  input  logic                       rst,
  input  logic                       ev_valid,
  output logic                       ev_ready,
  input  logic                       ev_on,
  input  logic [6:0]                 ev_note,
  input  logic [18:0]                ev_period,
  input  logic                       all_off,
  output logic [19*NUM_VOICES-1:0]   voice_period,
  output logic [NUM_VOICES-1:0]      voice_active,
  output logic                       ev_dropped,
  output logic                       ev_stolen
);
  localparam int IW = $clog2(NUM_VOICES);
  typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [6:0] note [NUM_VOICES];
  logic [18:0] period [NUM_VOICES];
  logic [7:0] stamp [NUM_VOICES];
  logic [7:0] seq;
  logic l_on;
  logic [6:0] l_note;
  logic [18:0] l_period;
  logic hit_ok, free_ok;
  logic [IW-1:0] hit_idx, free_idx;
  logic last;
  assign last = idx == IW'(NUM_VOICES - 1);
`ifdef VOICE_STEAL_EN
  logic old_ok;
  logic [IW-1:0] old_idx;
  logic [7:0] old_age, age;
  assign age = seq - stamp[idx];
`endif
  // Inactive slots always hold period 0, so the period store drives the outputs directly.
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
    assign voice_period[19*v +: 19] = period[v];
  end
  // Next state: panic returns to IDLE from anywhere.
  always_comb begin
    state_n = all_off ? IDLE :
              state == IDLE ? (ev_valid ? SCAN : IDLE) :
              state == SCAN ? (last ? APPLY : SCAN) : IDLE;
  end
  // State register, with ready registered from the next state.
  always_ff @(posedge clk48m) begin
    state <= rst ? IDLE : state_n;
    ev_ready <= rst || state_n == IDLE;
  end
  // Event latch, slot scan and commit of the allocation decision.
  always_ff @(posedge clk48m) begin
    ev_dropped <= 1'b0;
    ev_stolen <= 1'b0;
    if (rst) begin
      seq <= '0;
      idx <= '0;
      voice_active <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note[i] <= '0;
        period[i] <= '0;
        stamp[i] <= '0;
      end
    end else if (all_off) begin
      voice_active <= '0;
      for (int i = 0; i < NUM_VOICES; i++) period[i] <= '0;
    end else if (state == IDLE) begin
      if (ev_valid) begin
        l_on <= ev_on && ev_period != '0;
        l_note <= ev_note;
        l_period <= ev_period;
        idx <= '0;
        hit_ok <= 1'b0;
        free_ok <= 1'b0;
`ifdef VOICE_STEAL_EN
        old_ok <= 1'b0;
`endif
      end
    end else if (state == SCAN) begin
      idx <= idx + IW'(1);
      if (voice_active[idx] && note[idx] == l_note && !hit_ok) begin
        hit_ok <= 1'b1;
        hit_idx <= idx;
      end
      if (!voice_active[idx] && !free_ok) begin
        free_ok <= 1'b1;
        free_idx <= idx;
      end
`ifdef VOICE_STEAL_EN
      if (voice_active[idx] && (!old_ok || age > old_age)) begin
        old_ok <= 1'b1;
        old_idx <= idx;
        old_age <= age;
      end
`endif
    end else begin
      if (!l_on) begin
        if (hit_ok) begin
          voice_active[hit_idx] <= 1'b0;
          period[hit_idx] <= '0;
        end
      end else if (hit_ok) begin
        period[hit_idx] <= l_period;
        stamp[hit_idx] <= seq;
        seq <= seq + 8'd1;
      end else if (free_ok) begin
        voice_active[free_idx] <= 1'b1;
        note[free_idx] <= l_note;
        period[free_idx] <= l_period;
        stamp[free_idx] <= seq;
        seq <= seq + 8'd1;
      end else begin
`ifdef VOICE_STEAL_EN
        note[old_idx] <= l_note;
        period[old_idx] <= l_period;
        stamp[old_idx] <= seq;
        seq <= seq + 8'd1;
        ev_stolen <= 1'b1;
`else
        ev_dropped <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: randomized and directed checks of voice_allocator against a slot-table reference model
module tb_voice_allocator;
  localparam int NV = 4;
  logic clk48m = 1'b0;
  logic rst, ev_valid, ev_on, all_off;
  logic [6:0] ev_note;
  logic [18:0] ev_period;
  logic ev_ready, ev_dropped, ev_stolen;
  logic [19*NV-1:0] voice_period;
  logic [NV-1:0] voice_active;
  int n_checks = 0;
  int n_fail = 0;
  bit m_act [NV];
  bit [6:0] m_note [NV];
  bit [18:0] m_per [NV];
  int m_stamp [NV];
  int m_seq;
  bit m_stl, m_drp;

  voice_allocator #(.NUM_VOICES(NV)) dut (
    .clk48m(clk48m), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .ev_period(ev_period), .all_off(all_off),
    .voice_period(voice_period), .voice_active(voice_active),
    .ev_dropped(ev_dropped), .ev_stolen(ev_stolen)
  );

  always #5 clk48m = ~clk48m;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 0;
      m_per[i] = 0;
    end
  endtask

  // Allocation rules: match first, then lowest free slot, then steal oldest or drop.
  task automatic model_ev(input bit on, input bit [6:0] n, input bit [18:0] p);
    int hit, fre, old, oage, a, tgt;
    hit = -1; fre = -1; old = -1; oage = -1; tgt = -1;
    m_stl = 0;
    m_drp = 0;
    for (int i = 0; i < NV; i++) begin
      a = (m_seq - m_stamp[i]) & 255;
      if (m_act[i] && m_note[i] == n && hit < 0) hit = i;
      if (!m_act[i] && fre < 0) fre = i;
      if (m_act[i] && a > oage) begin old = i; oage = a; end
    end
    if (!on || p == 0) begin
      if (hit >= 0) begin m_act[hit] = 0; m_per[hit] = 0; end
    end else begin
      if (hit >= 0) tgt = hit;
      else if (fre >= 0) tgt = fre;
      else begin
`ifdef VOICE_STEAL_EN
        tgt = old;
        m_stl = 1;
`else
        m_drp = 1;
`endif
      end
      if (tgt >= 0) begin
        m_act[tgt] = 1;
        m_note[tgt] = n;
        m_per[tgt] = p;
        m_stamp[tgt] = m_seq;
        m_seq = (m_seq + 1) % 256;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [19*NV-1:0] pv;
    logic [NV-1:0] mk;
    for (int i = 0; i < NV; i++) begin
      mk[i] = m_act[i];
      pv[19*i +: 19] = m_act[i] ? m_per[i] : 19'd0;
    end
    check({tag, "_active"}, voice_active, mk);
    check({tag, "_period"}, voice_period, pv);
    check({tag, "_stolen"}, ev_stolen, m_stl);
    check({tag, "_dropped"}, ev_dropped, m_drp);
    check({tag, "_ready"}, ev_ready, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1; ev_valid = 0; all_off = 0; ev_on = 0; ev_note = 0; ev_period = 0;
    repeat (2) @(posedge clk48m);
    #1 rst = 0;
    model_clear();
    for (int i = 0; i < NV; i++) begin m_stamp[i] = 0; m_note[i] = 0; end
    m_seq = 0;
    m_stl = 0;
    m_drp = 0;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!ev_ready && t < 50) begin @(posedge clk48m); #1; t++; end
    check("ready_wait", ev_ready, 1'b1);
  endtask

  task automatic send(input bit on, input bit [6:0] n, input bit [18:0] p, input bit hold);
    wait_ready();
    ev_valid = 1; ev_on = on; ev_note = n; ev_period = p;
    @(posedge clk48m); #1;
    ev_valid = hold;
    model_ev(on, n, p);
    check("busy_first", ev_ready, 1'b0);
    repeat (NV) @(posedge clk48m);
    #1;
    check("busy_last", ev_ready, 1'b0);
    @(posedge clk48m); #1;
    ev_valid = 0;
    compare_all("ev");
  endtask

  initial begin
    do_reset();
    check("rst_ready", ev_ready, 1'b1);
    check("rst_active", voice_active, '0);
    check("rst_period", voice_period, '0);
    check("rst_pulses", {ev_stolen, ev_dropped}, 2'b00);

    send(1, 60, 1000, 0);
    check("first_slot0", voice_period[18:0], 19'd1000);

    do_reset();
    send(1, 60, 11, 0); send(1, 62, 22, 1); send(1, 64, 33, 0); send(1, 65, 44, 0);
    send(0, 62, 0, 0);
    check("off_mask", voice_active, 4'b1101);
    check("off_slot1", voice_period[19 +: 19], 19'd0);
    send(1, 67, 777, 0);
    check("reuse_slot1", voice_period[19 +: 19], 19'd777);

    do_reset();
    send(1, 60, 1000, 0);
    send(1, 60, 500, 0);
    check("retrig_mask", voice_active, 4'b0001);
    check("retrig_per", voice_period[18:0], 19'd500);
    send(1, 60, 0, 0);
    check("zero_is_off", voice_active, 4'b0000);

    do_reset();
    send(1, 60, 11, 0); send(1, 62, 22, 0); send(1, 64, 33, 0); send(1, 65, 44, 0);
    send(1, 69, 999, 0);
`ifdef VOICE_STEAL_EN
    check("steal_pulse", ev_stolen, 1'b1);
    check("steal_slot0", voice_period[18:0], 19'd999);
`else
    check("drop_pulse", ev_dropped, 1'b1);
    check("drop_slot0", voice_period[18:0], 19'd11);
`endif
    @(posedge clk48m); #1;
    check("pulse_once", {ev_stolen, ev_dropped}, 2'b00);

    do_reset();
    send(1, 60, 123, 0);
    wait_ready();
    ev_valid = 1; ev_on = 1; ev_note = 62; ev_period = 456;
    @(posedge clk48m); #1;
    ev_valid = 0;
    @(posedge clk48m); #1;
    all_off = 1;
    @(posedge clk48m); #1;
    all_off = 0;
    model_clear();
    m_stl = 0;
    m_drp = 0;
    compare_all("alloff");
    repeat (NV + 2) @(posedge clk48m);
    #1;
    compare_all("alloff_after");

    do_reset();
    send(1, 10, 111, 0);
    send(1, 20, 222, 0);
    for (int i = 0; i < 300; i++) send(1, 10, 19'(1000 + i), 0);
    send(1, 30, 333, 0);
    send(1, 40, 444, 0);
    send(1, 50, 555, 0);
`ifdef VOICE_STEAL_EN
    check("wrap_steal_slot1", voice_period[19 +: 19], 19'd555);
`else
    check("wrap_drop", ev_dropped, 1'b1);
`endif

    do_reset();
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        wait_ready();
        all_off = 1;
        @(posedge clk48m); #1;
        all_off = 0;
        model_clear();
        m_stl = 0;
        m_drp = 0;
        compare_all("rnd_alloff");
      end else begin
        send($urandom_range(0, 9) < 6, 7'($urandom_range(40, 47)),
             $urandom_range(0, 9) == 0 ? 19'd0 : 19'($urandom_range(1, 524287)),
             1'($urandom_range(0, 1)));
      end
      repeat ($urandom_range(0, 2)) @(posedge clk48m);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
